mult_ctrl_fsm: RTL and testbench

// - Parametrised control unit for the sequential shift-add multiplier datapath plus display-window selector.
// - Sequences load, add and shift steps from datapath flags (z_flag, b0) with a bounded iteration count.
// - Raises done/busy status and runs a scroll window over the BCD digits from the left/right buttons.
// - Sits between the button synchronisers and the multiplier datapath / 7-seg driver.

---
 rtl/mult_ctrl_fsm_pkg.sv | 18 +
 rtl/mult_ctrl_fsm_if.sv | 32 +++
 rtl/win_sel_counter.sv | 35 +++
 rtl/mult_ctrl_fsm.sv | 126 ++++++++++++
 tb/tb_mult_ctrl_fsm.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mult_ctrl_fsm_pkg.sv
// Shared types and helpers for the shift-add multiplier control unit.
package mult_ctrl_fsm_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StCheck = 3'd2,
        StAdd   = 3'd3,
        StShift = 3'd4,
        StDone  = 3'd5
    } state_e;

    // Width of a 0..n-1 index, never narrower than one bit.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mult_ctrl_fsm_if.sv
// Button, datapath-flag and control/status bundle between the control unit and its neighbours.
interface mult_ctrl_fsm_if
    import mult_ctrl_fsm_pkg::*;
#(
    parameter int unsigned N_WIN = 4
) ();

    localparam int unsigned SelW = sel_width(N_WIN);

    logic            btn_l;
    logic            btn_r;
    logic            btn_c;
    logic            z_flag;
    logic            b0;
    logic            load;
    logic            add_en;
    logic            shift_en;
    logic            busy;
    logic            done;
    logic [SelW-1:0] sel;

    modport master (
        input  btn_l, btn_r, btn_c, z_flag, b0,
        output load, add_en, shift_en, busy, done, sel
    );

    modport slave (
        output btn_l, btn_r, btn_c, z_flag, b0,
        input  load, add_en, shift_en, busy, done, sel
    );

endinterface

// File: rtl/win_sel_counter.sv
// Display window index: steps up on i_inc, down on i_dec, saturating or wrapping at the ends.
module win_sel_counter
    import mult_ctrl_fsm_pkg::*;
#(
    parameter int unsigned N_WIN = 4,
    parameter int unsigned WRAP  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_inc,
    input  logic                           i_dec,
    output logic [sel_width(N_WIN)-1:0]    o_sel
);

    localparam int unsigned     SelW   = sel_width(N_WIN);
    localparam logic [SelW-1:0] SelMax = SelW'(N_WIN - 1);

    logic [SelW-1:0] r_sel;

    // Simultaneous inc and dec cancel out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_sel == SelMax) r_sel <= (WRAP != 0) ? '0 : SelMax;
            else                 r_sel <= r_sel + SelW'(1);
        end else if (i_dec && !i_inc) begin
            if (r_sel == '0) r_sel <= (WRAP != 0) ? SelMax : '0;
            else             r_sel <= r_sel - SelW'(1);
        end
    end

    assign o_sel = r_sel;

endmodule

// File: rtl/mult_ctrl_fsm.sv
// Shift-add multiplier sequencer with button edge detection and a scrolling display window.
module mult_ctrl_fsm
    import mult_ctrl_fsm_pkg::*;
#(
    parameter int unsigned N_BITS = 8,
    parameter int unsigned N_WIN  = 4,
    parameter int unsigned WRAP   = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    mult_ctrl_fsm_if.master io_bus
);

    localparam int unsigned      IterW   = $clog2(N_BITS + 1);
    localparam logic [IterW-1:0] IterMax = IterW'(N_BITS);
    localparam int unsigned      SelW    = sel_width(N_WIN);

    state_e          r_state;
    logic [IterW-1:0] r_iter;
    logic            r_load;
    logic            r_add;
    logic            r_shift;
    logic            r_busy;
    logic            r_done;
    logic            r_btn_l;
    logic            r_btn_r;
    logic            r_btn_c;
    logic            w_l_edge;
    logic            w_r_edge;
    logic            w_c_edge;
    logic [SelW-1:0] w_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_l <= 1'b0;
            r_btn_r <= 1'b0;
            r_btn_c <= 1'b0;
        end else begin
            r_btn_l <= io_bus.btn_l;
            r_btn_r <= io_bus.btn_r;
            r_btn_c <= io_bus.btn_c;
        end
    end

    assign w_l_edge = io_bus.btn_l & ~r_btn_l;
    assign w_r_edge = io_bus.btn_r & ~r_btn_r;
    assign w_c_edge = io_bus.btn_c & ~r_btn_c;

    // Outputs are registered alongside the state so each one is valid for the state it belongs to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
            r_iter  <= '0;
            r_load  <= 1'b0;
            r_add   <= 1'b0;
            r_shift <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_load  <= 1'b0;
            r_add   <= 1'b0;
            r_shift <= 1'b0;
            if (w_c_edge) begin
                // Start, or abort and restart, from any state.
                r_state <= StLoad;
                r_iter  <= '0;
                r_load  <= 1'b1;
                r_busy  <= 1'b1;
                r_done  <= 1'b0;
            end else begin
                case (r_state)
                    StIdle, StDone: begin
                    end
                    StLoad: begin
                        r_state <= StCheck;
                    end
                    StCheck: begin
                        if (io_bus.z_flag || (r_iter == IterMax)) begin
                            r_state <= StDone;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else if (io_bus.b0) begin
                            r_state <= StAdd;
                            r_add   <= 1'b1;
                        end else begin
                            r_state <= StShift;
                            r_shift <= 1'b1;
                        end
                    end
                    StAdd: begin
                        r_state <= StShift;
                        r_shift <= 1'b1;
                    end
                    StShift: begin
                        r_state <= StCheck;
                        r_iter  <= r_iter + IterW'(1);
                    end
                    default: begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b0;
                    end
                endcase
            end
        end
    end

    win_sel_counter #(
        .N_WIN (N_WIN),
        .WRAP  (WRAP)
    ) u_win_sel (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_l_edge),
        .i_dec (w_r_edge),
        .o_sel (w_sel)
    );

    assign io_bus.load     = r_load;
    assign io_bus.add_en   = r_add;
    assign io_bus.shift_en = r_shift;
    assign io_bus.busy     = r_busy;
    assign io_bus.done     = r_done;
    assign io_bus.sel      = w_sel;

endmodule

// File: tb/tb_mult_ctrl_fsm.sv
// Bench for mult_ctrl_fsm: datapath model, multiply scoreboard and window-index checks.
module tb_mult_ctrl_fsm;

    localparam int unsigned NB = 8;
    localparam int unsigned NW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    mult_ctrl_fsm_if #(.N_WIN(NW)) bus ();
    mult_ctrl_fsm_if #(.N_WIN(NW)) bus_w ();

    mult_ctrl_fsm #(.N_BITS(NB), .N_WIN(NW), .WRAP(0)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus.master)
    );

    mult_ctrl_fsm #(.N_BITS(NB), .N_WIN(NW), .WRAP(1)) dut_w (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_w.master)
    );

    int checks    = 0;
    int failures  = 0;
    int n_add     = 0;
    int n_shift   = 0;
    int excl_viol = 0;

    // Datapath model driven by the control pulses.
    logic [15:0] dp_mcand;
    logic [15:0] dp_prod;
    logic [7:0]  dp_mplier;
    logic [7:0]  op_a;
    logic [7:0]  op_b;
    logic        dp_force;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dp_mcand  <= '0;
            dp_prod   <= '0;
            dp_mplier <= '0;
        end else if (bus.load) begin
            dp_mcand  <= {8'h00, op_a};
            dp_mplier <= op_b;
            dp_prod   <= '0;
        end else begin
            if (bus.add_en) dp_prod <= dp_prod + dp_mcand;
            if (bus.shift_en) begin
                dp_mcand  <= dp_mcand << 1;
                dp_mplier <= dp_mplier >> 1;
            end
        end
    end

    assign bus.z_flag   = dp_force ? 1'b0 : (dp_mplier == 8'h00);
    assign bus.b0       = dp_force ? 1'b1 : dp_mplier[0];
    assign bus_w.z_flag = 1'b0;
    assign bus_w.b0     = 1'b0;

    always @(posedge clk) begin
        if (bus.add_en)   n_add   <= n_add + 1;
        if (bus.shift_en) n_shift <= n_shift + 1;
    end

    always @(negedge clk) begin
        if (rst_n && ((bus.add_en && bus.shift_en) || (bus.load && (bus.add_en || bus.shift_en))))
            excl_viol <= excl_viol + 1;
    end

    typedef struct {
        logic [15:0] prod;
        int          adds;
        int          shifts;
        int          lat;
    } exp_t;

    exp_t sb_q[$];

    // Start a multiply at the current negedge and check it through to done.
    task automatic run_mult(input string name, input logic [7:0] a, input logic [7:0] b,
                            input logic frc);
        exp_t        e;
        logic [7:0]  m;
        int          base_add;
        int          base_shift;
        int          cyc;
        bit          got;
        op_a     = a;
        op_b     = b;
        dp_force = frc;
        e.adds   = 0;
        e.shifts = 0;
        if (frc) begin
            e.prod   = 16'(a) * 16'd255;
            e.adds   = NB;
            e.shifts = NB;
        end else begin
            e.prod = 16'(a) * 16'(b);
            m = b;
            while (m != 8'h00) begin
                e.adds   += int'(m[0]);
                e.shifts += 1;
                m = m >> 1;
            end
        end
        e.lat = 2 + 2 * e.shifts + e.adds;
        sb_q.push_back(e);
        bus.btn_c = 1'b1;
        @(negedge clk);
        bus.btn_c = 1'b0;
        checks++;
        if ({bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done} !== 5'b10010) begin
            failures++;
            $display("FAIL %s load_cycle got=%b exp=10010", name,
                     {bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done});
        end
        base_add   = n_add;
        base_shift = n_shift;
        cyc = 0;
        got = 1'b0;
        while (cyc < 100 && !got) begin
            @(negedge clk);
            cyc++;
            if (bus.done) got = 1'b1;
        end
        e = sb_q.pop_front();
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s done_timeout got=no_done exp=done_within_100", name);
            return;
        end
        checks++;
        if (dp_prod !== e.prod) begin
            failures++;
            $display("FAIL %s product got=%0d exp=%0d", name, dp_prod, e.prod);
        end
        checks++;
        if ((n_add - base_add) !== e.adds) begin
            failures++;
            $display("FAIL %s adds got=%0d exp=%0d", name, n_add - base_add, e.adds);
        end
        checks++;
        if ((n_shift - base_shift) !== e.shifts) begin
            failures++;
            $display("FAIL %s shifts got=%0d exp=%0d", name, n_shift - base_shift, e.shifts);
        end
        checks++;
        if (cyc !== e.lat) begin
            failures++;
            $display("FAIL %s latency got=%0d exp=%0d", name, cyc, e.lat);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_at_done got=%b exp=0", name, bus.busy);
        end
    endtask

    task automatic win_press(input bit use_w, input bit l, input bit r, input int hold);
        if (use_w) begin
            bus_w.btn_l = l;
            bus_w.btn_r = r;
        end else begin
            bus.btn_l = l;
            bus.btn_r = r;
        end
        repeat (hold) @(negedge clk);
        bus.btn_l   = 1'b0;
        bus.btn_r   = 1'b0;
        bus_w.btn_l = 1'b0;
        bus_w.btn_r = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done, bus.sel} !== 7'b0) begin
            failures++;
            $display("FAIL reset_state got=%b exp=0",
                     {bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done, bus.sel});
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        win_press(1'b0, 1'b1, 1'b0, 1);
        checks++;
        if (bus.sel !== 2'd1) begin
            failures++;
            $display("FAIL reset_mid_presel got=%0d exp=1", bus.sel);
        end
        op_a = 8'd5;
        op_b = 8'hFF;
        dp_force = 1'b1;
        bus.btn_c = 1'b1;
        @(negedge clk);
        bus.btn_c = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done, bus.sel} !== 7'b0) begin
            failures++;
            $display("FAIL reset_mid got=%b exp=0",
                     {bus.load, bus.add_en, bus.shift_en, bus.busy, bus.done, bus.sel});
        end
        @(negedge clk);
        rst_n = 1'b1;
        dp_force = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mult_13x11();
        run_mult("mult_13x11", 8'd13, 8'd11, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1) begin
            failures++;
            $display("FAIL done_hold got=%b exp=1", bus.done);
        end
    endtask

    task automatic test_zero();
        run_mult("zero_mplier", 8'd77, 8'd0, 1'b0);
    endtask

    task automatic test_bound();
        run_mult("iter_bound", 8'd3, 8'hFF, 1'b1);
        dp_force = 1'b0;
    endtask

    task automatic test_restart();
        int sc = 0;
        int lim = 0;
        op_a = 8'd13;
        op_b = 8'd11;
        bus.btn_c = 1'b1;
        @(negedge clk);
        bus.btn_c = 1'b0;
        while (sc < 3 && lim < 60) begin
            @(negedge clk);
            lim++;
            if (bus.shift_en) sc++;
        end
        checks++;
        if (sc !== 3) begin
            failures++;
            $display("FAIL restart_reach_shift got=%0d exp=3", sc);
        end
        run_mult("restart", 8'd7, 8'd5, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_mult("b2b_first", 8'd200, 8'd3, 1'b0);
        run_mult("b2b_second", 8'd255, 8'd255, 1'b0);
    endtask

    task automatic test_window();
        logic [1:0] exp_l [5];
        exp_l[0] = 2'd1;
        exp_l[1] = 2'd2;
        exp_l[2] = 2'd3;
        exp_l[3] = 2'd3;
        exp_l[4] = 2'd3;
        for (int i = 0; i < 5; i++) begin
            win_press(1'b0, 1'b1, 1'b0, 3);
            checks++;
            if (bus.sel !== exp_l[i]) begin
                failures++;
                $display("FAIL win_left_%0d got=%0d exp=%0d", i, bus.sel, exp_l[i]);
            end
        end
        win_press(1'b0, 1'b1, 1'b1, 2);
        checks++;
        if (bus.sel !== 2'd3) begin
            failures++;
            $display("FAIL win_both got=%0d exp=3", bus.sel);
        end
        for (int i = 0; i < 4; i++) begin
            win_press(1'b0, 1'b0, 1'b1, 1);
            checks++;
            if (bus.sel !== ((i < 3) ? 2'(2 - i) : 2'd0)) begin
                failures++;
                $display("FAIL win_right_%0d got=%0d exp=%0d", i, bus.sel,
                         (i < 3) ? (2 - i) : 0);
            end
        end
        win_press(1'b0, 1'b1, 1'b0, 1);
        run_mult("win_during_mult", 8'd3, 8'd2, 1'b0);
        checks++;
        if (bus.sel !== 2'd1) begin
            failures++;
            $display("FAIL win_btn_c_keeps_sel got=%0d exp=1", bus.sel);
        end
    endtask

    task automatic test_wrap();
        win_press(1'b1, 1'b0, 1'b1, 1);
        checks++;
        if (bus_w.sel !== 2'd3) begin
            failures++;
            $display("FAIL wrap_down got=%0d exp=3", bus_w.sel);
        end
        win_press(1'b1, 1'b1, 1'b0, 1);
        checks++;
        if (bus_w.sel !== 2'd0) begin
            failures++;
            $display("FAIL wrap_up got=%0d exp=0", bus_w.sel);
        end
        win_press(1'b1, 1'b1, 1'b0, 1);
        checks++;
        if (bus_w.sel !== 2'd1) begin
            failures++;
            $display("FAIL wrap_step got=%0d exp=1", bus_w.sel);
        end
    endtask

    task automatic test_exclusive();
        checks++;
        if (excl_viol !== 0) begin
            failures++;
            $display("FAIL pulse_exclusive got=%0d exp=0", excl_viol);
        end
    endtask

    initial begin
        bus.btn_l   = 1'b0;
        bus.btn_r   = 1'b0;
        bus.btn_c   = 1'b0;
        bus_w.btn_l = 1'b0;
        bus_w.btn_r = 1'b0;
        bus_w.btn_c = 1'b0;
        op_a        = 8'd0;
        op_b        = 8'd0;
        dp_force    = 1'b0;
        test_reset();
        test_reset_mid();
        test_mult_13x11();
        test_zero();
        test_bound();
        test_restart();
        test_back_to_back();
        test_window();
        test_wrap();
        test_exclusive();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
